// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared constants and types for the instruction decode stage:
//                instruction field positions, reg_sel codes, state encoding
//                and the decoded-field bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package decode_pkg;

    localparam int c_ir_w     = 16;
    localparam int c_num_opc  = 8;

    // Instruction field bit positions
    localparam int c_opc_hi   = 15;
    localparam int c_opc_lo   = 13;
    localparam int c_alu_hi   = 12;
    localparam int c_alu_lo   = 11;
    localparam int c_rn_hi    = 10;
    localparam int c_rn_lo    = 8;
    localparam int c_rd_hi    = 7;
    localparam int c_rd_lo    = 5;
    localparam int c_sh_hi    = 4;
    localparam int c_sh_lo    = 3;
    localparam int c_rm_hi    = 2;
    localparam int c_rm_lo    = 0;
    localparam int c_imm5_hi  = 4;
    localparam int c_imm8_hi  = 7;

    // Register-select codes
    localparam logic [1:0] c_sel_rm  = 2'b00;
    localparam logic [1:0] c_sel_rd  = 2'b01;
    localparam logic [1:0] c_sel_rn  = 2'b10;
    localparam logic [1:0] c_sel_inv = 2'b11;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] alu_op;
        logic [1:0] shift_op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [2:0] rm;
    } decoded_t;

endpackage
`default_nettype wire

// File: rtl/decode_fields.sv
`default_nettype none
// ============================================================================
//  Module      : decode_fields
//  Description : Combinational field split, immediate sign extension and
//                register selection for one instruction word. All outputs
//                except o_sel_err read as zero when i_valid is low.
//  Ports       : i_valid    - instruction word is meaningful
//                i_ir       - 16-bit instruction word
//                i_reg_sel  - 10=Rn, 01=Rd, 00=Rm, 11=invalid
//                o_dec      - decoded field bundle
//                o_sximm5   - ir[4:0] sign-extended to DATA_W
//                o_sximm8   - ir[7:0] sign-extended to DATA_W
//                o_reg_addr - register chosen by i_reg_sel
//                o_sel_err  - i_reg_sel is the invalid code
//  Revision    : 1.0  initial release
// ============================================================================
module decode_fields
    import decode_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_valid,
    input  logic [15:0]       i_ir,
    input  logic [1:0]        i_reg_sel,
    output decoded_t          o_dec,
    output logic [DATA_W-1:0] o_sximm5,
    output logic [DATA_W-1:0] o_sximm8,
    output logic [2:0]        o_reg_addr,
    output logic              o_sel_err
);

    // Gating the word once makes every derived field read zero when idle.
    logic [15:0] w_ir;
    assign w_ir = i_valid ? i_ir : 16'h0000;

    assign o_dec.opcode   = w_ir[c_opc_hi:c_opc_lo];
    assign o_dec.alu_op   = w_ir[c_alu_hi:c_alu_lo];
    assign o_dec.shift_op = w_ir[c_sh_hi:c_sh_lo];
    assign o_dec.rn       = w_ir[c_rn_hi:c_rn_lo];
    assign o_dec.rd       = w_ir[c_rd_hi:c_rd_lo];
    assign o_dec.rm       = w_ir[c_rm_hi:c_rm_lo];

    assign o_sximm5 = {{(DATA_W-5){w_ir[c_imm5_hi]}}, w_ir[c_imm5_hi:0]};
    assign o_sximm8 = {{(DATA_W-8){w_ir[c_imm8_hi]}}, w_ir[c_imm8_hi:0]};

    assign o_sel_err = (i_reg_sel == c_sel_inv);

    always_comb begin
        o_reg_addr = 3'd0;
        case (i_reg_sel)
            c_sel_rn: o_reg_addr = w_ir[c_rn_hi:c_rn_lo];
            c_sel_rd: o_reg_addr = w_ir[c_rd_hi:c_rd_lo];
            c_sel_rm: o_reg_addr = w_ir[c_rm_hi:c_rm_lo];
            default:  o_reg_addr = 3'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction decode stage built around a two-entry skid
//                buffer. Raw words are buffered; decode is combinational from
//                the main (head) entry.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                in_valid/in_ready   - upstream handshake, ir_in word
//                out_valid/out_ready - downstream handshake
//                opcode..sximm8      - decoded head-entry fields
//                reg_sel             - selects r_addr/w_addr source
//                sel_err, illegal    - select / opcode error flags
//                dec_count           - accepted-instruction counter
//  Revision    : 1.0  initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int         DATA_W    = 16,
    parameter logic [7:0] LEGAL_OPC = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       ir_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        opcode,
    output logic [1:0]        alu_op,
    output logic [1:0]        shift_op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    input  logic [1:0]        reg_sel,
    output logic [2:0]        r_addr,
    output logic [2:0]        w_addr,
    output logic              sel_err,
    output logic              illegal,
    output logic [15:0]       dec_count
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_main;
    logic [15:0] r_skid;
    logic        r_in_ready;
    logic [15:0] r_dec_count;

    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_load_main;
    logic        w_load_skid;
    logic        w_main_from_skid;

    assign in_ready   = r_in_ready;
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = out_valid & out_ready;
    assign dec_count  = r_dec_count;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_load_main = 1'b1;
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main = 1'b1;
                end else if (w_in_xfer) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only the output side can move.
                if (w_out_xfer) begin
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = S_ONE;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_main      <= 16'h0000;
            r_skid      <= 16'h0000;
            r_in_ready  <= 1'b1;
            r_dec_count <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            // Registered ready looks ahead at the next state so it drops
            // in the same cycle the buffer becomes full.
            r_in_ready <= (w_state_nxt != S_FULL);
            if (w_load_main) begin
                r_main <= ir_in;
            end else if (w_main_from_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= ir_in;
            end
            if (w_in_xfer) begin
                r_dec_count <= r_dec_count + 16'd1;
            end
        end
    end

    decoded_t    w_dec;
    logic [2:0]  w_reg_addr;

    decode_fields #(
        .DATA_W (DATA_W)
    ) u_fields (
        .i_valid    (out_valid),
        .i_ir       (r_main),
        .i_reg_sel  (reg_sel),
        .o_dec      (w_dec),
        .o_sximm5   (sximm5),
        .o_sximm8   (sximm8),
        .o_reg_addr (w_reg_addr),
        .o_sel_err  (sel_err)
    );

    assign opcode   = w_dec.opcode;
    assign alu_op   = w_dec.alu_op;
    assign shift_op = w_dec.shift_op;
    assign rn       = w_dec.rn;
    assign rd       = w_dec.rd;
    assign rm       = w_dec.rm;
    assign r_addr   = w_reg_addr;
    assign w_addr   = w_reg_addr;
    assign illegal  = out_valid & ~LEGAL_OPC[w_dec.opcode];

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage
//                (DATA_W=16, LEGAL_OPC=8'h7F).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ir_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  opcode;
    logic [1:0]  alu_op;
    logic [1:0]  shift_op;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [1:0]  reg_sel;
    logic [2:0]  r_addr;
    logic [2:0]  w_addr;
    logic        sel_err;
    logic        illegal;
    logic [15:0] dec_count;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage #(
        .DATA_W    (16),
        .LEGAL_OPC (8'h7F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir_in     (ir_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .opcode    (opcode),
        .alu_op    (alu_op),
        .shift_op  (shift_op),
        .rn        (rn),
        .rd        (rd),
        .rm        (rm),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .reg_sel   (reg_sel),
        .r_addr    (r_addr),
        .w_addr    (w_addr),
        .sel_err   (sel_err),
        .illegal   (illegal),
        .dec_count (dec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ir_in     = 16'h0000;
        reg_sel   = 2'b00;

        // Reset state
        step();
        step();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_dec_count", 32'(dec_count), 32'd0);
        check_eq("rst_opcode",    32'(opcode),    32'd0);
        rst_n = 1'b1;

        // Single instruction A143
        ir_in = 16'hA143; in_valid = 1'b1; out_ready = 1'b1; reg_sel = 2'b10;
        step();
        in_valid = 1'b0;
        check_eq("a143_valid",  32'(out_valid), 32'd1);
        check_eq("a143_opcode", 32'(opcode),    32'd5);
        check_eq("a143_alu",    32'(alu_op),    32'd0);
        check_eq("a143_rn",     32'(rn),        32'd1);
        check_eq("a143_rd",     32'(rd),        32'd2);
        check_eq("a143_rm",     32'(rm),        32'd3);
        check_eq("a143_imm5",   32'(sximm5),    32'h0003);
        check_eq("a143_raddr",  32'(r_addr),    32'd1);
        step();
        check_eq("a143_gone",   32'(out_valid), 32'd0);
        check_eq("idle_opcode", 32'(opcode),    32'd0);
        check_eq("idle_raddr",  32'(r_addr),    32'd0);
        check_eq("cnt_1",       32'(dec_count), 32'd1);

        // Negative immediate D080 and register selection
        out_ready = 1'b0; ir_in = 16'hD080; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("d080_imm8",   32'(sximm8),  32'hFF80);
        check_eq("d080_imm5",   32'(sximm5),  32'h0000);
        check_eq("d080_alu",    32'(alu_op),  32'd2);
        check_eq("d080_raddr",  32'(r_addr),  32'd0);
        check_eq("d080_waddr",  32'(w_addr),  32'd0);
        check_eq("d080_selerr", 32'(sel_err), 32'd0);
        check_eq("d080_legal",  32'(illegal), 32'd0);
        reg_sel = 2'b01; #1;
        check_eq("sel_rd_raddr", 32'(r_addr), 32'd4);
        check_eq("sel_rd_waddr", 32'(w_addr), 32'd4);
        reg_sel = 2'b11; #1;
        check_eq("sel_inv_err",   32'(sel_err), 32'd1);
        check_eq("sel_inv_raddr", 32'(r_addr),  32'd0);
        check_eq("sel_inv_waddr", 32'(w_addr),  32'd0);
        reg_sel = 2'b00;
        out_ready = 1'b1;
        step();
        check_eq("d080_gone", 32'(out_valid), 32'd0);

        // Illegal opcode 111 with LEGAL_OPC=7F still passes downstream
        out_ready = 1'b0; ir_in = 16'hE005; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("ill_flag",   32'(illegal), 32'd1);
        check_eq("ill_opcode", 32'(opcode),  32'd7);
        check_eq("ill_rm",     32'(rm),      32'd5);
        out_ready = 1'b1;
        step();
        check_eq("ill_idle", 32'(illegal),   32'd0);
        check_eq("cnt_3",    32'(dec_count), 32'd3);

        // Backpressure: three back-to-back words, downstream stalled
        out_ready = 1'b0; in_valid = 1'b1; ir_in = 16'h2001;
        step();
        check_eq("bp1_ready",  32'(in_ready), 32'd1);
        check_eq("bp1_opcode", 32'(opcode),   32'd1);
        ir_in = 16'h4002;
        step();
        check_eq("bp2_ready",  32'(in_ready), 32'd0);
        check_eq("bp2_head",   32'(opcode),   32'd1);
        ir_in = 16'h6003;
        step();
        check_eq("bp3_ready",  32'(in_ready), 32'd0);
        check_eq("bp3_head",   32'(opcode),   32'd1);
        check_eq("bp3_rm",     32'(rm),       32'd1);
        check_eq("bp3_cnt",    32'(dec_count), 32'd5);
        out_ready = 1'b1;
        step();
        check_eq("drain2_op",    32'(opcode),   32'd2);
        check_eq("drain2_rm",    32'(rm),       32'd2);
        check_eq("drain2_ready", 32'(in_ready), 32'd1);
        // Simultaneous accept and consume in ONE
        step();
        in_valid = 1'b0;
        check_eq("drain3_valid", 32'(out_valid), 32'd1);
        check_eq("drain3_op",    32'(opcode),    32'd3);
        check_eq("drain3_rm",    32'(rm),        32'd3);
        check_eq("drain3_ready", 32'(in_ready),  32'd1);
        step();
        check_eq("drain_empty",  32'(out_valid), 32'd0);
        check_eq("cnt_6",        32'(dec_count), 32'd6);

        // Reset while FULL with dec_count = 5
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1; ir_in = 16'h2001;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        step();
        check_eq("full_cnt",   32'(dec_count), 32'd5);
        check_eq("full_ready", 32'(in_ready),  32'd0);
        check_eq("full_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready),  32'd1);
        check_eq("mid_rst_cnt",   32'(dec_count), 32'd0);
        rst_n = 1'b1;

        // Counter wrap under continuous traffic
        for (int i = 0; i < 65535; i++) step();
        check_eq("wrap_ffff",  32'(dec_count), 32'hFFFF);
        check_eq("wrap_valid", 32'(out_valid), 32'd1);
        step();
        check_eq("wrap_zero",  32'(dec_count), 32'd0);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 16; width of sign-extended immediates, legal range 16..32.
REQ-002 Parameter LEGAL_OPC, default 8'hFF; bit k set means opcode k is legal.
REQ-003 clk  input  1  the block's one clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  ir_in holds an instruction.
REQ-006 in_ready  output  1  stage accepts an instruction this cycle; driven directly from a register.
REQ-007 ir_in  input  16  instruction word.
REQ-008 out_valid  output  1  the decoded outputs hold a valid instruction.
REQ-009 out_ready  input  1  downstream consumes the decoded instruction this cycle.
REQ-010 opcode / alu_op / shift_op  output  3/2/2  ir[15:13] / ir[12:11] / ir[4:3].
REQ-011 rn / rd / rm  output  3 each  ir[10:8] / ir[7:5] / ir[2:0].
REQ-012 sximm5 / sximm8  output  DATA_W each  ir[4:0] / ir[7:0], sign-extended.
REQ-013 reg_sel  input  2  register select: 10=Rn, 01=Rd, 00=Rm, 11=invalid.
REQ-014 r_addr / w_addr  output  3 each  register chosen by reg_sel from the head entry.
REQ-015 sel_err  output  1  set when reg_sel = 11.
REQ-016 illegal  output  1  set when LEGAL_OPC[opcode] = 0 for the head entry.
REQ-017 dec_count  output  16  number of instructions accepted.

Function
REQ-018 Transfer rules: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-019 The stage is a two-entry skid buffer (main entry + skid entry).
REQ-020 Each entry stores the raw 16-bit instruction; all decode is combinational from the main entry.
REQ-021 State machine:
- EMPTY: no entry valid.
- ONE: main entry valid.
- FULL: main and skid entries valid.
REQ-022 From EMPTY: on input transfer, load main and go to ONE.
REQ-023 From ONE:
- input only: load skid, go to FULL.
- output only: go to EMPTY.
- both at once: overwrite main, stay in ONE.
REQ-024 From FULL: on output transfer, move skid to main and go to ONE; no input transfer is possible in FULL.
REQ-025 in_ready = 0 exactly in FULL; out_valid = 1 in ONE and FULL.
REQ-026 Latency: an instruction accepted at edge N appears on the outputs with out_valid after edge N; there is no bubble under continuous traffic.
REQ-027 Ordering: instructions leave in acceptance order, none dropped or duplicated; the main entry stays stable while out_valid=1 and out_ready=0.
REQ-028 Sign extension: replicate bit 4 (sximm5) or bit 7 (sximm8) up to DATA_W-1.
REQ-029 When reg_sel = 11: r_addr = w_addr = 0 and sel_err = 1; otherwise sel_err = 0.
REQ-030 All decoded outputs, r_addr, w_addr and illegal read as 0 when out_valid = 0.
REQ-031 dec_count increments by 1 per input transfer and wraps from 16'hFFFF to 0.
REQ-032 illegal does not block the transfer; the instruction is passed downstream flagged.

Reset
REQ-033 While rst_n = 0 at an edge:
- state goes to EMPTY; both entries and dec_count clear to 0.
- in_ready = 1 from the first edge after reset.
- out_valid = 0.
REQ-034 A reset mid-operation discards both entries; no transfer completes on a reset edge.

Structure
REQ-035 A shared package (decode_pkg) holds:
- the opcode, reg_sel and state-encoding constants.
- the ir field bit positions.
- a typedef for the decoded bundle.
REQ-036 One sub-module, decode_fields, performs the combinational field split, sign extension and reg_sel selection; it is instantiated once, on the main entry.

Verification
REQ-037 Single instruction: ir_in=16'hA143 with out_ready=1. Required:
- opcode=101, alu_op=00, rn=1, rd=2, rm=3, sximm5=16'h0003.
- out_valid=1 for one cycle.
REQ-038 Negative immediate: ir_in=16'hD080 with DATA_W=16. Required:
- sximm8=16'hFF80.
- with reg_sel=10, r_addr=w_addr=0.
REQ-039 Backpressure: send 3 instructions back-to-back with out_ready=0. Required:
- in_ready falls after the 2nd is accepted.
- after out_ready=1, the outputs show the 1st, then the 2nd, then the 3rd, in order.
REQ-040 Simultaneous accept and consume in ONE: state stays ONE and the outputs update to the new instruction on the next cycle.
REQ-041 reg_sel=11: sel_err=1 and r_addr=0. With LEGAL_OPC=8'h7F and opcode 111: illegal=1.
REQ-042 Reset mid-stream while FULL, with dec_count=5. Required:
- out_valid=0, in_ready=1, dec_count=0.
- 16'hFFFF+1 accepts wrap dec_count to 0.
